// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, unsigned or
// two's-complement operands, valid/ready handshake on both sides.
module seq_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] mul
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   mcand_q, mcand_d;   // multiplicand, extended to PW bits, shifted left per step
   logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right per step
   logic            sgn_q, sgn_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [PW-1:0]   mul_q, mul_d;
   logic            last;
   logic [PW-1:0]   addend;

   // Next-state, datapath step and handshake outputs
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      sgn_d     = sgn_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      mul_d     = mul_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      addend    = '0;
      last      = (cnt_q == LastCnt);

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mcand_d  = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
               mplier_d = b;
               sgn_d    = signed_mode;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = StBusy;
            end
         end
         StBusy: begin
            // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so subtract it.
            if (mplier_q[0]) begin
               addend = (last && sgn_q) ? (~mcand_q + PW'(1)) : mcand_q;
            end
            acc_d    = acc_q + addend;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
            if (last) begin
               mul_d   = acc_d;
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         sgn_q    <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         mul_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sgn_q    <= sgn_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         mul_q    <= mul_d;
      end
   end

   assign mul = mul_q;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: an 8-bit instance for directed and random
// operations, and a 2-bit instance swept exhaustively in both modes.
module tb_seq_mult;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 8-bit instance
   logic        v8, r8, s8, ov8, or8;
   logic [7:0]  a8, b8;
   logic [15:0] m8;
   // 2-bit instance
   logic        v2, r2, s2, ov2, or2;
   logic [1:0]  a2, b2;
   logic [3:0]  m2;

   seq_mult #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
      .signed_mode(s8), .out_valid(ov8), .out_ready(or8), .mul(m8)
   );

   seq_mult #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2),
      .signed_mode(s2), .out_valid(ov2), .out_ready(or2), .mul(m2)
   );

   longint unsigned exp8_q[$];
   int              cyc8_q[$];
   longint unsigned exp2_q[$];
   int              cyc2_q[$];

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: interpret operands as integers, multiply, keep 2*w bits.
   function automatic longint unsigned ref_mul(input int w, input longint unsigned x,
                                               input longint unsigned y, input bit s);
      longint sx, sy, p;
      sx = longint'(x);
      sy = longint'(y);
      if (s && x[w-1]) sx = sx - (longint'(1) << w);
      if (s && y[w-1]) sy = sy - (longint'(1) << w);
      p = sx * sy;
      return longint'(unsigned'(p)) & ((longint'(1) << (2 * w)) - 1);
   endfunction

   // Monitors: pop on the first cycle of out_valid, then check the product holds.
   bit              seen8 = 1'b0, seen2 = 1'b0;
   longint unsigned last8, last2;

   always @(negedge clk) begin
      if (ov8 === 1'b1) begin
         if (!seen8) begin
            if (exp8_q.size() == 0 || cyc8_q.size() == 0) begin
               chk("w8_unexpected_valid", 1, 0);
               last8 = m8;
            end else begin
               last8 = exp8_q.pop_front();
               chk("w8_mul", m8, last8);
               chk("w8_latency", cyc - cyc8_q.pop_front(), 8);
            end
         end else begin
            chk("w8_hold", m8, last8);
         end
      end
      seen8 = (ov8 === 1'b1);
   end

   always @(negedge clk) begin
      if (ov2 === 1'b1) begin
         if (!seen2) begin
            if (exp2_q.size() == 0 || cyc2_q.size() == 0) begin
               chk("w2_unexpected_valid", 1, 0);
               last2 = m2;
            end else begin
               last2 = exp2_q.pop_front();
               chk("w2_mul", m2, last2);
               chk("w2_latency", cyc - cyc2_q.pop_front(), 2);
            end
         end else begin
            chk("w2_hold", m2, last2);
         end
      end
      seen2 = (ov2 === 1'b1);
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue8(input logic [7:0] x, input logic [7:0] y, input bit s, input bit exp_out);
      int guard = 0;
      while (r8 !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (r8 !== 1'b1) begin
         chk("w8_ready_timeout", 0, 1);
         return;
      end
      a8 = x; b8 = y; s8 = s; v8 = 1'b1;
      if (exp_out) exp8_q.push_back(ref_mul(8, x, y, s));
      @(negedge clk);
      v8 = 1'b0;
      if (exp_out) cyc8_q.push_back(cyc);
   endtask

   task automatic issue2(input logic [1:0] x, input logic [1:0] y, input bit s);
      int guard = 0;
      while (r2 !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (r2 !== 1'b1) begin
         chk("w2_ready_timeout", 0, 1);
         return;
      end
      a2 = x; b2 = y; s2 = s; v2 = 1'b1;
      exp2_q.push_back(ref_mul(2, x, y, s));
      @(negedge clk);
      v2 = 1'b0;
      cyc2_q.push_back(cyc);
   endtask

   // Scramble inputs during BUSY; none of it may reach the result.
   task automatic busy_noise8(input int n);
      for (int i = 0; i < n; i++) begin
         a8  = 8'($urandom);
         b8  = 8'($urandom);
         s8  = 1'($urandom);
         v8  = 1'($urandom);
         or8 = 1'($urandom);
         @(negedge clk);
      end
      v8  = 1'b0;
      or8 = 1'b1;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while ((exp8_q.size() != 0 || exp2_q.size() != 0 || r8 !== 1'b1 || r2 !== 1'b1)
             && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk(name, guard < 300, 1);
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
      v2 = 1'b0; a2 = '0; b2 = '0; s2 = 1'b0; or2 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready8", r8, 1);
      chk("rst_out_valid8", ov8, 0);
      chk("rst_mul8", m8, 0);
      chk("rst_in_ready2", r2, 1);
      chk("rst_out_valid2", ov2, 0);
      rst = 1'b0;

      // First accept on the first edge after reset, then signed corner cases
      issue8(8'hFF, 8'hFF, 1'b0, 1'b1);
      issue8(8'h80, 8'h80, 1'b1, 1'b1);
      issue8(8'hFF, 8'h7F, 1'b1, 1'b1);
      issue8(8'h00, 8'hAB, 1'b0, 1'b1);
      busy_noise8(6);
      issue8(8'h5A, 8'hC3, 1'b1, 1'b1);
      busy_noise8(6);
      drain("drain_directed");

      // Backpressure in DONE
      or8 = 1'b0;
      issue8(8'hFF, 8'hFF, 1'b0, 1'b1);
      guard = 0;
      while (ov8 !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("bp_valid_seen", ov8, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_mul_held", m8, 16'hFE01);
         chk("bp_valid_held", ov8, 1);
         chk("bp_in_ready_low", r8, 0);
      end
      or8 = 1'b1;
      @(negedge clk);
      chk("bp_valid_cleared", ov8, 0);
      chk("bp_idle_ready", r8, 1);

      // Reset in the 4th BUSY cycle aborts; then a fresh 3*3
      issue8(8'd200, 8'd100, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_in_ready", r8, 1);
      chk("abort_out_valid", ov8, 0);
      chk("abort_mul", m8, 0);
      repeat (12) @(negedge clk);
      issue8(8'd3, 8'd3, 1'b0, 1'b1);
      drain("drain_abort");

      // Random operations
      for (int i = 0; i < 40; i++) begin
         issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end
      drain("drain_random");

      // WIDTH=2 exhaustive, both modes
      for (int s = 0; s < 2; s++) begin
         for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
               issue2(2'(x), 2'(y), 1'(s));
            end
         end
      end
      drain("drain_w2");

      chk("w8_queue_empty", exp8_q.size(), 0);
      chk("w2_queue_empty", exp2_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operands a, b and signed_mode are valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-009 SHALL have port out_valid  output  1  product is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the product.
REQ-011 SHALL have port mul  output  2*WIDTH  product.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-014 SHALL accept an operation when in_valid=1 and in_ready=1 at a rising edge: capture a, b and signed_mode, clear the accumulator and bit counter, and go IDLE->BUSY.
REQ-015 SHALL ignore a, b and signed_mode at all times except the accept edge; mid-operation input changes SHALL NOT affect the result.
REQ-016 SHALL process one multiplier bit per BUSY cycle (shift-add), staying in BUSY for exactly WIDTH rising edges, then go BUSY->DONE.
REQ-017 SHALL assert out_valid on the WIDTH-th rising edge after the accept edge, including when either operand is zero (no early termination).
REQ-018 SHALL hold mul and out_valid stable in DONE until out_ready=1 at a rising edge, then go DONE->IDLE and clear out_valid.
REQ-019 SHALL NOT accept a new operation in the same cycle as the output handshake; minimum issue interval is WIDTH+2 cycles.
REQ-020 SHALL, when signed_mode=0, produce mul = a*b as unsigned 2*WIDTH bits, exact with no overflow.
REQ-021 SHALL, when signed_mode=1, produce mul = a*b as a two's-complement 2*WIDTH-bit value, exact for all operand pairs, including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2).
REQ-022 SHALL hold mul at its last value in IDLE and BUSY; mul is meaningful only while out_valid=1.
REQ-023 SHALL give out_ready no effect outside DONE, and in_valid no effect outside IDLE.
REQ-024 SHALL for WIDTH=2, signed_mode=0, produce results identical to the existing 2-bit combinational multiplier for all 16 operand pairs.

Reset
REQ-025 SHALL, while rst=1 at a rising edge, force IDLE, in_ready=1 from the next cycle, out_valid=0, mul=0, and counter=0.
REQ-026 SHALL let rst take priority over every handshake; reset asserted in BUSY or DONE SHALL abort the operation with no product delivered.
REQ-027 SHALL make the first accept possible on the first rising edge after rst deasserts.

Verification
REQ-028 SHALL cover WIDTH=8 unsigned a=255, b=255 -> mul=0xFE01, out_valid exactly 8 edges after accept.
REQ-029 SHALL cover WIDTH=8 signed a=0x80, b=0x80 -> mul=0x4000; and signed a=0xFF, b=0x7F -> mul=0xFF81.
REQ-030 SHALL cover WIDTH=8 unsigned a=0, b=0xAB -> mul=0 with full 8-cycle latency; a and b toggled during BUSY -> result unchanged.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> mul and out_valid held, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-032 SHALL cover rst=1 pulse at the 4th BUSY cycle -> out_valid never asserted, in_ready=1 after reset, and a fresh 3*3 then yields mul=9.
REQ-033 SHALL cover WIDTH=2 exhaustively, both modes -> all 32 results match the reference model; e.g. signed 2'b10*2'b10 -> 4'b0100.
